// File: rtl/game_ctrl.sv
// game_ctrl: TITLE/PLAY/GAME_OVER sequencer with lives, saturating score and post-hit invulnerability.
module game_ctrl #(
  parameter int unsigned LIVES_INIT    = 3,
  parameter int unsigned INVULN_FRAMES = 60,
  parameter int unsigned OVER_HOLD     = 120,
  parameter int unsigned SCORE_MAX     = 255
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       pixpulse,
  input  logic       move,
  input  logic       move_up,
  input  logic       move_down,
  input  logic       move_left,
  input  logic       move_right,
  input  logic       hit,
  input  logic [2:0] score_inc,
  output logic [1:0] state,
  output logic [1:0] lives,
  output logic [7:0] score,
  output logic       obj_rst,
  output logic       invuln,
  output logic       flash
);
  typedef enum logic [1:0] {TITLE = 2'b00, PLAY = 2'b01, OVER = 2'b10} state_t;
  state_t     state_q, state_d;
  logic [1:0] lives_q, lives_d;
  logic [7:0] score_q, score_d;
  logic [7:0] inv_q, inv_d;
  logic [7:0] hold_q, hold_d;
  logic [7:0] frame_q;
  logic [3:0] btn_q;
  logic       obj_q, obj_d;
  logic       start;
  logic [3:0] btn;
  logic [8:0] sc_sum;
  assign btn    = {move_up, move_down, move_left, move_right};
  assign sc_sum = {1'b0, score_q} + 9'(score_inc[0]) + 9'(score_inc[1]) + 9'(score_inc[2]);
  always_comb begin
    state_d = state_q;
    lives_d = lives_q;
    score_d = score_q;
    inv_d   = inv_q;
    hold_d  = hold_q;
    obj_d   = 1'b0;
    start   = 1'b0;
    case (state_q)
      TITLE: start = |(btn & ~btn_q);
      PLAY: begin
        score_d = sc_sum > 9'(SCORE_MAX) ? 8'(SCORE_MAX) : sc_sum[7:0];
        if (hit && inv_q == 8'd0) begin
          if (lives_q > 2'd1) begin
            lives_d = lives_q - 2'd1;
            inv_d   = 8'(INVULN_FRAMES);
          end else begin
            lives_d = 2'd0;
            state_d = OVER;
            hold_d  = 8'd0;
          end
        end else if (move && inv_q != 8'd0) inv_d = inv_q - 8'd1;
      end
      OVER: begin
        if (move && hold_q < 8'(OVER_HOLD)) hold_d = hold_q + 8'd1;
        start = hold_q == 8'(OVER_HOLD) && &btn;
      end
      default: state_d = TITLE;
    endcase
    // a new game reloads everything and pulses obj_rst for one pixel slot
    if (start) begin
      state_d = PLAY;
      lives_d = 2'(LIVES_INIT);
      score_d = 8'd0;
      inv_d   = 8'd0;
      obj_d   = 1'b1;
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= TITLE;
      lives_q <= 2'(LIVES_INIT);
      score_q <= 8'd0;
      inv_q   <= 8'd0;
      hold_q  <= 8'd0;
      frame_q <= 8'd0;
      btn_q   <= 4'd0;
      obj_q   <= 1'b0;
    end else if (pixpulse) begin
      state_q <= state_d;
      lives_q <= lives_d;
      score_q <= score_d;
      inv_q   <= inv_d;
      hold_q  <= hold_d;
      frame_q <= frame_q + 8'(move);
      btn_q   <= btn;
      obj_q   <= obj_d;
    end
  end
  assign state   = state_q;
  assign lives   = lives_q;
  assign score   = score_q;
  assign obj_rst = obj_q;
  assign invuln  = |inv_q;
  assign flash   = invuln & frame_q[3];
endmodule

// File: tb/tb_game_ctrl.sv
// tb_game_ctrl: directed stimulus with a queue scoreboard popped by a pixpulse-driven monitor.
module tb_game_ctrl;
  logic       clk, rst, pixpulse, move, move_up, move_down, move_left, move_right, hit;
  logic [2:0] score_inc;
  logic [1:0] state, lives;
  logic [7:0] score;
  logic       obj_rst, invuln, flash;
  logic [14:0] got;
  typedef struct {
    logic [14:0] exp;
    logic [14:0] msk;
    int          tag;
  } ent_t;
  ent_t sb[$];
  int total = 0, bad = 0;
  localparam logic [14:0] ALL = 15'h7fff, NONE = 15'h0000;

  game_ctrl dut (
    .clk(clk), .rst(rst), .pixpulse(pixpulse), .move(move),
    .move_up(move_up), .move_down(move_down), .move_left(move_left), .move_right(move_right),
    .hit(hit), .score_inc(score_inc), .state(state), .lives(lives), .score(score),
    .obj_rst(obj_rst), .invuln(invuln), .flash(flash)
  );
  assign got = {state, lives, score, obj_rst, invuln, flash};

  // 100 MHz clock, pixpulse every fourth cycle, changed only on falling edges
  initial begin
    clk = 0;
    pixpulse = 0;
    forever begin
      for (int i = 0; i < 4; i++) begin
        pixpulse = (i == 3);
        #5 clk = 1;
        #5 clk = 0;
      end
    end
  end

  function automatic logic [14:0] e(input logic [1:0] st, input logic [1:0] lv, input logic [7:0] sc,
                                    input logic ob, input logic iv, input logic fl);
    return {st, lv, sc, ob, iv, fl};
  endfunction

  task automatic check(input int tag, input logic [14:0] g, input logic [14:0] x, input logic [14:0] m);
    total++;
    if ((g & m) !== (x & m)) begin
      bad++;
      $display("FAIL tag=%0d got{st,lv,sc,obj,inv,fl}=%h expected=%h mask=%h", tag, g, x, m);
    end
  endtask

  always @(posedge clk) begin
    ent_t t;
    if (pixpulse) begin
      #1;
      if (sb.size() != 0) begin
        t = sb.pop_front();
        if (t.msk != NONE) check(t.tag, got, t.exp, t.msk);
      end
    end
  end

  task automatic step(input logic [3:0] b, input logic mv, input logic h, input logic [2:0] si,
                      input logic [14:0] x, input logic [14:0] m, input int tag);
    do @(negedge clk); while (!pixpulse);
    {move_up, move_down, move_left, move_right} = b;
    move = mv;
    hit = h;
    score_inc = si;
    sb.push_back('{x, m, tag});
    @(posedge clk);
    #2;
    move = 0;
    hit = 0;
    score_inc = 0;
  endtask

  initial begin
    logic [7:0] fr;
    rst = 1;
    {move, move_up, move_down, move_left, move_right, hit} = '0;
    score_inc = 0;
    repeat (6) @(posedge clk);
    #1 check(1, got, e(0, 3, 0, 0, 0, 0), ALL);
    @(negedge clk);
    rst = 0;
    // TITLE ignores hit/score, then a left press starts the game
    step(4'b0000, 0, 1, 3'b111, e(0, 3, 0, 0, 0, 0), ALL, 101);
    step(4'b0010, 0, 0, 3'b000, e(1, 3, 0, 1, 0, 0), ALL, 102);
    step(4'b0000, 0, 0, 3'b000, e(1, 3, 0, 0, 0, 0), ALL, 103);
    step(4'b0000, 0, 0, 3'b001, e(1, 3, 1, 0, 0, 0), ALL, 104);
    // held hit costs one life only
    for (int k = 1; k <= 10; k++) step(4'b0000, 0, 1, 3'b000, e(1, 2, 1, 0, 1, 0), ALL, 300 + k);
    for (int k = 1; k <= 60; k++) begin
      fr = 8'(k);
      step(4'b0000, 1, 0, 3'b000, e(1, 2, 1, 0, k < 60, (k < 60) && fr[3]), ALL, 400 + k);
    end
    // hit and move together: hit taken, counter loads, frame still advances to 61
    step(4'b0000, 1, 1, 3'b000, e(1, 1, 1, 0, 1, 1), ALL, 500);
    for (int k = 1; k <= 60; k++) begin
      fr = 8'(61 + k);
      step(4'b0000, 1, 0, 3'b000, e(1, 1, 1, 0, k < 60, (k < 60) && fr[3]), ALL, 500 + k);
    end
    // losing hit still counts score pulses
    step(4'b0000, 0, 1, 3'b011, e(2, 0, 3, 0, 0, 0), ALL, 600);
    for (int j = 1; j <= 130; j++)
      step((j == 50 || j == 120) ? 4'b1111 : 4'b0000, 1, 1, 3'b111, e(2, 0, 3, 0, 0, 0),
           (j == 50 || j == 120 || j == 130) ? ALL : NONE, 700 + j);
    step(4'b1111, 0, 0, 3'b000, e(1, 3, 0, 1, 0, 0), ALL, 900);
    // saturating score
    for (int i = 1; i <= 100; i++)
      step(4'b0000, 0, 0, 3'b111, e(1, 3, (3 * i > 255) ? 8'd255 : 8'(3 * i), 0, 0, 0), ALL, 1000 + i);
    // frame count is now 251 (bit 3 set), so flash follows invuln
    step(4'b0000, 0, 1, 3'b000, e(1, 2, 255, 0, 1, 1), ALL, 1200);
    @(negedge clk);
    #2 rst = 1;
    #1 check(1201, got, e(0, 3, 0, 0, 0, 0), ALL);
    repeat (8) @(posedge clk);
    #1 check(1202, got, e(0, 3, 0, 0, 0, 0), ALL);
    @(negedge clk);
    rst = 0;
    step(4'b0000, 0, 0, 3'b000, e(0, 3, 0, 0, 0, 0), ALL, 1203);
    step(4'b1000, 0, 0, 3'b000, e(1, 3, 0, 1, 0, 0), ALL, 1204);
    repeat (8) @(posedge clk);
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_drain left=%0d expected=0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
